// File: rtl/sdram_types.sv
// sdram_types: shared client count and arbiter state encoding
package sdram_types;
  localparam int NCLIENT = 4;
  typedef enum logic {IDLE, ISSUE} arb_state_t;
endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: combinational 4-way round-robin picker, first eligible at or after ptr
module sdram_rr_pick
  import sdram_types::*;
(
  input  logic [NCLIENT-1:0] eligible,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         idx
);
  always_comb begin
    idx = ptr;
    for (int k = NCLIENT - 1; k >= 0; k--)
      if (eligible[ptr + 2'(k)]) idx = ptr + 2'(k);
  end
  assign any = |eligible;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter of four clients onto the SDRAM request port with read return demux
module sdram_arbiter
  import sdram_types::*;
#(
  parameter int AN     = 24,
  parameter int DN     = 16,
  parameter int BURST  = 8,
  parameter int MAXOUT = 2
) (
  input  logic                       clkSYS,
  input  logic                       n_reset,
  input  logic [NCLIENT-1:0][AN-1:0] c_addr,
  input  logic [NCLIENT-1:0][DN-1:0] c_data,
  input  logic [NCLIENT-1:0]         c_req,
  input  logic [NCLIENT-1:0]         c_wr,
  output logic [NCLIENT-1:0]         c_ack,
  output logic [DN-1:0]              c_rdata,
  output logic [NCLIENT-1:0]         c_rvalid,
  output logic [AN-1:0]              req_addr,
  output logic [DN-1:0]              req_data,
  output logic [1:0]                 req_id,
  output logic                       req,
  output logic                       req_wr,
  input  logic                       req_ack,
  input  logic [DN-1:0]              mem_data,
  input  logic [1:0]                 mem_id,
  input  logic                       mem_valid,
  output logic                       err
);
  localparam int WW = BURST > 1 ? $clog2(BURST) : 1;
  localparam int OW = $clog2(MAXOUT + 1);
  arb_state_t          state;
  logic [1:0]          ptr;
  logic [1:0]          pick;
  logic                any;
  logic [NCLIENT-1:0]  eligible;
  logic [OW-1:0]       outst [NCLIENT];
  assign c_ack = (req && req_ack) ? NCLIENT'(1) << req_id : '0;
  sdram_rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .any      (any),
    .idx      (pick)
  );
  for (genvar i = 0; i < NCLIENT; i++) begin : g_cl
    logic [WW-1:0] wcnt;
    logic          hit;
    logic          inc;
    logic          dec;
    assign eligible[i] = c_req[i] && (c_wr[i] || outst[i] < OW'(MAXOUT));
    assign hit = mem_valid && mem_id == 2'(i);
    assign inc = c_ack[i] && !req_wr;
    assign dec = hit && wcnt == WW'(BURST - 1) && outst[i] != '0;
    always_ff @(posedge clkSYS)
      if (!n_reset) begin
        wcnt     <= '0;
        outst[i] <= '0;
      end else begin
        if (hit) wcnt <= (wcnt == WW'(BURST - 1)) ? '0 : wcnt + 1'b1;
        outst[i] <= outst[i] + OW'(inc) - OW'(dec);
      end
  end
  always_ff @(posedge clkSYS)
    if (!n_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      req      <= 1'b0;
      req_wr   <= 1'b0;
      req_id   <= '0;
      req_addr <= '0;
      req_data <= '0;
      c_rdata  <= '0;
      c_rvalid <= '0;
      err      <= 1'b0;
    end else begin
      c_rdata  <= mem_data;
      c_rvalid <= mem_valid ? NCLIENT'(1) << mem_id : '0;
      err      <= err | (mem_valid && outst[mem_id] == '0);
      if (state == IDLE && any) begin
        state    <= ISSUE;
        req      <= 1'b1;
        req_id   <= pick;
        req_wr   <= c_wr[pick];
        req_addr <= c_addr[pick];
        req_data <= c_data[pick];
      end else if (state == ISSUE && req_ack) begin
        state <= IDLE;
        req   <= 1'b0;
        ptr   <= req_id + 2'd1;
      end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a transaction-level model
module tb_sdram_arbiter;
  localparam int AN = 24, DN = 16, BURST = 8, MAXOUT = 2;
  logic clkSYS = 1'b0;
  logic n_reset;
  logic [3:0][AN-1:0] c_addr;
  logic [3:0][DN-1:0] c_data;
  logic [3:0] c_req, c_wr, c_ack, c_rvalid;
  logic [DN-1:0] c_rdata, req_data, mem_data;
  logic [AN-1:0] req_addr;
  logic [1:0] req_id, mem_id;
  logic req, req_wr, req_ack, mem_valid, err;
  always #5 clkSYS = ~clkSYS;
  sdram_arbiter #(.AN(AN), .DN(DN), .BURST(BURST), .MAXOUT(MAXOUT)) dut (
    .clkSYS    (clkSYS),
    .n_reset   (n_reset),
    .c_addr    (c_addr),
    .c_data    (c_data),
    .c_req     (c_req),
    .c_wr      (c_wr),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .c_rvalid  (c_rvalid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_id    (req_id),
    .req       (req),
    .req_wr    (req_wr),
    .req_ack   (req_ack),
    .mem_data  (mem_data),
    .mem_id    (mem_id),
    .mem_valid (mem_valid),
    .err       (err)
  );
  int n_vec = 0, n_bad = 0, cyc = 0;
  bit m_busy, m_wr, m_err;
  int m_ptr, m_win;
  logic [AN-1:0] m_addr;
  logic [DN-1:0] m_data, m_rdata;
  logic [3:0] m_rvalid;
  int m_acked [4];
  int m_words [4];
  logic [3:0] last_ack;
  int rd_grant;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int outst(input int c);
    return m_acked[c] - m_words[c] / BURST;
  endfunction
  task automatic tick();
    logic [3:0] ea;
    int o [4];
    int c;
    #1;
    ea = (m_busy && req_ack) ? 4'(1 << m_win) : 4'b0;
    last_ack = c_ack;
    chk("c_ack", c_ack, ea);
    rd_grant = -1;
    if (!n_reset) begin
      m_busy = 0; m_ptr = 0; m_win = 0; m_wr = 0; m_err = 0;
      m_addr = '0; m_data = '0; m_rdata = '0; m_rvalid = '0;
      for (int k = 0; k < 4; k++) begin m_acked[k] = 0; m_words[k] = 0; end
    end else begin
      for (int k = 0; k < 4; k++) o[k] = outst(k);
      m_rdata = mem_data;
      m_rvalid = mem_valid ? 4'(1 << mem_id) : 4'b0;
      if (mem_valid) begin
        if (o[mem_id] == 0) m_err = 1;
        m_words[mem_id]++;
      end
      if (m_busy) begin
        if (req_ack) begin
          m_busy = 0;
          m_ptr = (m_win + 1) % 4;
          if (!m_wr) begin m_acked[m_win]++; rd_grant = m_win; end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!m_busy && c_req[c] && (c_wr[c] || o[c] < MAXOUT)) begin
            m_busy = 1; m_win = c; m_wr = c_wr[c]; m_addr = c_addr[c]; m_data = c_data[c];
          end
        end
      end
    end
    @(posedge clkSYS);
    @(negedge clkSYS);
    cyc++;
    chk("req", req, m_busy);
    chk("req_id", req_id, m_win);
    chk("req_wr", req_wr, m_wr);
    chk("req_addr", req_addr, m_addr);
    chk("req_data", req_data, m_data);
    chk("c_rvalid", c_rvalid, m_rvalid);
    chk("c_rdata", c_rdata, m_rdata);
    chk("err", err, m_err);
  endtask
  task automatic reset_dut();
    n_reset = 0; c_req = '0; c_wr = '0; req_ack = 0; mem_valid = 0;
    tick();
    tick();
    n_reset = 1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int gq [$];
    int gt [$];
    int bq [$];
    int acks, wc;
    bit got;
    c_addr = '0; c_data = '0; c_req = '0; c_wr = '0; req_ack = 0;
    mem_valid = 0; mem_id = '0; mem_data = '0; n_reset = 0;
    m_busy = 0; m_win = 0;
    @(negedge clkSYS);
    reset_dut();
    chk("rst_req", req, 0);
    chk("rst_err", err, 0);
    chk("rst_rvalid", c_rvalid, 0);
    c_req = 4'b0001; c_wr = 4'b0001; c_addr[0] = 24'h000010; c_data[0] = 16'hBEEF; req_ack = 1;
    tick();
    chk("t1_req", req, 1);
    chk("t1_id", req_id, 0);
    chk("t1_wr", req_wr, 1);
    chk("t1_addr", req_addr, 24'h000010);
    chk("t1_data", req_data, 16'hBEEF);
    #1 chk("t1_ack", c_ack, 4'b0001);
    tick();
    c_req = '0;
    chk("t1_drop", req, 0);
    tick();
    chk("t1_idle", req, 0);
    reset_dut();
    c_req = 4'b1111; c_wr = 4'b1111; req_ack = 1;
    for (int k = 0; k < 4; k++) begin c_addr[k] = AN'(k * 16); c_data[k] = DN'(k); end
    for (int n = 0; n < 10; n++) begin
      tick();
      for (int k = 0; k < 4; k++) if (last_ack[k]) begin gq.push_back(k); gt.push_back(cyc); end
    end
    c_req = '0;
    chk("t2_count", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++) begin
      chk("t2_order", gq[k], k % 4);
      if (k > 0) chk("t2_gap", gt[k] - gt[k-1], 2);
    end
    tick();
    c_req = 4'b0100; c_wr = 4'b0000; c_addr[2] = 24'h123456; req_ack = 0;
    tick();
    chk("t3_req", req, 1);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t3_addr", req_addr, 24'h123456);
      chk("t3_noack", last_ack, 4'b0000);
    end
    req_ack = 1;
    tick();
    chk("t3_ack", last_ack, 4'b0100);
    c_req = '0;
    tick();
    chk("t3_done", req, 0);
    reset_dut();
    c_req = 4'b0010; c_wr = 4'b0000; c_addr[1] = 24'h000100; req_ack = 1; acks = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (last_ack[1]) begin acks++; c_addr[1] = c_addr[1] + 24'h8; end
    end
    chk("t4_two", acks, 2);
    chk("t4_stall", req, 0);
    for (int k = 0; k < 8; k++) begin
      mem_valid = 1; mem_id = 2'd1; mem_data = DN'(16'h0400 + k);
      tick();
      if (last_ack[1]) acks++;
    end
    mem_valid = 0;
    chk("t4_hold", acks, 2);
    got = 0;
    for (int n = 0; n < 6 && !got; n++) begin
      tick();
      if (last_ack[1]) got = 1;
    end
    chk("t4_third", got, 1);
    c_req = '0;
    tick();
    c_req = 4'b1000; c_wr = 4'b0000; c_addr[3] = 24'h003000; got = 0;
    for (int n = 0; n < 4 && !got; n++) begin
      tick();
      if (last_ack[3]) got = 1;
    end
    chk("t5_issue", got, 1);
    c_req = '0;
    for (int k = 0; k < 8; k++) begin
      mem_valid = 1; mem_id = 2'd3; mem_data = DN'(16'h1000 + k);
      tick();
      chk("t5_rvalid", c_rvalid, 4'b1000);
      chk("t5_rdata", c_rdata, 16'h1000 + k);
    end
    mem_valid = 0;
    tick();
    chk("t5_rv_off", c_rvalid, 4'b0000);
    c_req = 4'b1000; acks = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (last_ack[3]) acks++;
    end
    chk("t5_outst0", acks, 2);
    c_req = '0;
    tick();
    mem_valid = 1; mem_id = 2'd2; mem_data = 16'hDEAD;
    tick();
    mem_valid = 0;
    chk("t6_err", err, 1);
    chk("t6_rvalid", c_rvalid, 4'b0100);
    for (int n = 0; n < 3; n++) tick();
    chk("t6_sticky", err, 1);
    c_req = 4'b0001; c_wr = 4'b0001; req_ack = 0;
    tick();
    chk("t6_issue", req, 1);
    n_reset = 0;
    tick();
    chk("t6_rst_req", req, 0);
    chk("t6_rst_err", err, 0);
    n_reset = 1; c_req = '0;
    tick();
    reset_dut();
    wc = 0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 4; c++)
        if (!c_req[c] || last_ack[c]) begin
          c_req[c] = ($urandom % 3) == 0;
          c_wr[c] = 1'($urandom % 2);
          c_addr[c] = AN'($urandom);
          c_data[c] = DN'($urandom);
        end
      req_ack = ($urandom % 3) != 0;
      if (bq.size() > 0 && ($urandom % 4) != 0) begin
        mem_valid = 1;
        mem_id = 2'(bq[0]);
        wc++;
        if (wc == BURST) begin void'(bq.pop_front()); wc = 0; end
      end else begin
        mem_valid = 0;
        mem_id = 2'($urandom);
      end
      mem_data = DN'($urandom);
      tick();
      if (rd_grant >= 0) bq.push_back(rd_grant);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
